dmem_port_arbiter: RTL and testbench

Arbitrates the single data-memory port between three requesters: the register-fetch stage's stack read, the execute stage's load/store, and the debug/host port. It sits between the pipeline and the data memory. It issues at most one access per cycle and stalls losing pipeline requesters. It tags each read so the one-cycle-latency read data returns to the requester that issued it.

---
 rtl/dmem_port_arbiter_pkg.sv | 18 +
 rtl/dmem_port_arbiter_starve_counter.sv | 25 ++
 rtl/dmem_port_arbiter.sv | 127 ++++++++++++
 tb/tb_dmem_port_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared owner tags and helpers for the data-memory port arbiter.
package dmem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        arb_own_none = 2'd0,
        arb_own_rf   = 2'd1,
        arb_own_ex   = 2'd2,
        arb_own_dbg  = 2'd3
    } arb_own_t;

    // Only accesses that produce a return (reads, and debug writes that need an ack) keep an owner.
    function automatic arb_own_t own_next(input arb_own_t grant, input logic ex_we);
        if (grant == arb_own_ex && ex_we)
            return arb_own_none;
        return grant;
    endfunction

endpackage

// File: rtl/dmem_port_arbiter_starve_counter.sv
// Saturating counter of denied debug cycles with an at-limit compare output.
module arb_starve_counter #(
    parameter int unsigned LIMIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);
    localparam int unsigned W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
    localparam logic [W-1:0] LIM = W'(LIMIT);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst || clr)
            cnt <= '0;
        else if (inc && cnt != LIM)
            cnt <= cnt + 1'b1;
    end

    assign at_limit = (cnt == LIM);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Single data-memory port shared by regfetch, execute and debug; tags reads for return.
// Optional debug anti-starvation guard enabled by defining DMEM_ARB_STARVE_GUARD_EN.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int DATA_MEM_SIZE_IN_BITS = 30,
    parameter int DBG_STARVE_LIMIT      = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             rf_req,
    input  logic [DATA_MEM_SIZE_IN_BITS-1:0] rf_adr,
    output logic                             rf_stall,
    output logic [31:0]                      rf_rdata,
    output logic                             rf_rvalid,
    input  logic                             ex_req,
    input  logic                             ex_we,
    input  logic [DATA_MEM_SIZE_IN_BITS-1:0] ex_adr,
    input  logic [31:0]                      ex_wdata,
    output logic                             ex_stall,
    output logic [31:0]                      ex_rdata,
    output logic                             ex_rvalid,
    input  logic                             dbg_req,
    input  logic                             dbg_we,
    input  logic [DATA_MEM_SIZE_IN_BITS-1:0] dbg_adr,
    input  logic [31:0]                      dbg_wdata,
    output logic                             dbg_ack,
    output logic [31:0]                      dbg_rdata,
    output logic                             mem_en,
    output logic                             mem_we,
    output logic [DATA_MEM_SIZE_IN_BITS-1:0] mem_adr,
    output logic [31:0]                      mem_wdata,
    input  logic [31:0]                      mem_rdata
);
    arb_own_t grant;
    arb_own_t own;
    logic     dbg_inflight;
    logic     rf_eff, ex_eff, dbg_eff;
    logic     grant_rf, grant_ex, grant_dbg;
    logic     dbg_force;

    assign rf_eff  = rf_req & ~flush;
    assign ex_eff  = ex_req;
    assign dbg_eff = dbg_req & ~dbg_inflight;

`ifdef DMEM_ARB_STARVE_GUARD_EN
    arb_starve_counter #(
        .LIMIT(DBG_STARVE_LIMIT)
    ) u_starve (
        .clk     (clk),
        .rst     (rst),
        .inc     (dbg_eff & ~grant_dbg),
        .clr     (grant_dbg | ~dbg_req),
        .at_limit(dbg_force)
    );
`else
    assign dbg_force = 1'b0;
`endif

    always_comb begin
        grant = arb_own_none;
        if (dbg_force && dbg_eff)
            grant = arb_own_dbg;
        else if (ex_eff)
            grant = arb_own_ex;
        else if (rf_eff)
            grant = arb_own_rf;
        else if (dbg_eff)
            grant = arb_own_dbg;
    end

    assign grant_rf  = (grant == arb_own_rf);
    assign grant_ex  = (grant == arb_own_ex);
    assign grant_dbg = (grant == arb_own_dbg);

    assign rf_stall = rf_eff & ~grant_rf;
    assign ex_stall = ex_req & ~grant_ex;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_adr   = '0;
        mem_wdata = '0;
        unique case (grant)
            arb_own_rf: begin
                mem_en  = 1'b1;
                mem_adr = rf_adr;
            end
            arb_own_ex: begin
                mem_en    = 1'b1;
                mem_we    = ex_we;
                mem_adr   = ex_adr;
                mem_wdata = ex_wdata;
            end
            arb_own_dbg: begin
                mem_en    = 1'b1;
                mem_we    = dbg_we;
                mem_adr   = dbg_adr;
                mem_wdata = dbg_wdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            own          <= arb_own_none;
            dbg_inflight <= 1'b0;
        end else begin
            own <= own_next(grant, ex_we);
            if (grant_dbg)
                dbg_inflight <= 1'b1;
            else if (dbg_ack)
                dbg_inflight <= 1'b0;
        end
    end

    assign rf_rvalid = (own == arb_own_rf) & ~flush;
    assign ex_rvalid = (own == arb_own_ex);
    assign dbg_ack   = (own == arb_own_dbg);

    assign rf_rdata  = mem_rdata;
    assign ex_rdata  = mem_rdata;
    assign dbg_rdata = mem_rdata;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: vector table plus multi-cycle sequences.
module tb_dmem_port_arbiter;
    localparam int AW = 30;
    localparam logic [AW-1:0] RF_A  = 30'h1ff8;
    localparam logic [AW-1:0] EX_A  = 30'h100;
    localparam logic [AW-1:0] DBG_A = 30'h40;
    localparam logic [31:0]   EX_D  = 32'hdeadbeef;
    localparam logic [31:0]   DBG_D = 32'h12345678;

    logic clk = 1'b0;
    logic rst, flush;
    logic rf_req, rf_stall, rf_rvalid;
    logic [AW-1:0] rf_adr;
    logic [31:0] rf_rdata;
    logic ex_req, ex_we, ex_stall, ex_rvalid;
    logic [AW-1:0] ex_adr;
    logic [31:0] ex_wdata, ex_rdata;
    logic dbg_req, dbg_we, dbg_ack;
    logic [AW-1:0] dbg_adr;
    logic [31:0] dbg_wdata, dbg_rdata;
    logic mem_en, mem_we;
    logic [AW-1:0] mem_adr;
    logic [31:0] mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter #(
        .DATA_MEM_SIZE_IN_BITS(AW),
        .DBG_STARVE_LIMIT     (8)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .rf_req(rf_req), .rf_adr(rf_adr), .rf_stall(rf_stall),
        .rf_rdata(rf_rdata), .rf_rvalid(rf_rvalid),
        .ex_req(ex_req), .ex_we(ex_we), .ex_adr(ex_adr), .ex_wdata(ex_wdata),
        .ex_stall(ex_stall), .ex_rdata(ex_rdata), .ex_rvalid(ex_rvalid),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_adr(dbg_adr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic rf, fl, ex, exwe, dbg, dbgwe;
        logic en, we;
        logic [1:0] src;
        logic rfst, exst;
        logic [1:0] ret;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        flush = 0; rf_req = 0; ex_req = 0; ex_we = 0; dbg_req = 0; dbg_we = 0;
    endtask

    function automatic logic [AW-1:0] exp_adr(input logic [1:0] src);
        case (src)
            2'd1: return RF_A;
            2'd2: return EX_A;
            2'd3: return DBG_A;
            default: return '0;
        endcase
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [1:0] src);
        case (src)
            2'd2: return EX_D;
            2'd3: return DBG_D;
            default: return '0;
        endcase
    endfunction

    initial begin
        logic [31:0] rd;

        //          rf fl ex we dbg dwe | en we src rfst exst ret
        vecs[0]  = '{0, 0, 0, 0, 0, 0,   0, 0, 2'd0, 0, 0, 2'd0};
        vecs[1]  = '{1, 0, 0, 0, 0, 0,   1, 0, 2'd1, 0, 0, 2'd1};
        vecs[2]  = '{0, 0, 1, 0, 0, 0,   1, 0, 2'd2, 0, 0, 2'd2};
        vecs[3]  = '{0, 0, 1, 1, 0, 0,   1, 1, 2'd2, 0, 0, 2'd0};
        vecs[4]  = '{1, 0, 1, 1, 0, 0,   1, 1, 2'd2, 1, 0, 2'd0};
        vecs[5]  = '{1, 0, 1, 0, 1, 0,   1, 0, 2'd2, 1, 0, 2'd2};
        vecs[6]  = '{1, 0, 0, 0, 1, 0,   1, 0, 2'd1, 0, 0, 2'd1};
        vecs[7]  = '{0, 0, 0, 0, 1, 0,   1, 0, 2'd3, 0, 0, 2'd3};
        vecs[8]  = '{0, 0, 0, 0, 1, 1,   1, 1, 2'd3, 0, 0, 2'd3};
        vecs[9]  = '{1, 1, 0, 0, 0, 0,   0, 0, 2'd0, 0, 0, 2'd0};
        vecs[10] = '{1, 1, 1, 0, 0, 0,   1, 0, 2'd2, 0, 0, 2'd2};
        vecs[11] = '{1, 1, 0, 0, 1, 0,   1, 0, 2'd3, 0, 0, 2'd3};
        vecs[12] = '{0, 0, 1, 1, 1, 1,   1, 1, 2'd2, 0, 0, 2'd0};

        rst = 0; idle_inputs();
        rf_adr = RF_A; ex_adr = EX_A; ex_wdata = EX_D; dbg_adr = DBG_A; dbg_wdata = DBG_D;
        mem_rdata = 32'h0;

        // Reset hold: nothing returns, stalls stay combinational.
        repeat (3) @(negedge clk);
        #1;
        check("reset_rf_rvalid", rf_rvalid, 0);
        check("reset_ex_rvalid", ex_rvalid, 0);
        check("reset_dbg_ack", dbg_ack, 0);

        // Release with an rf read.
        @(negedge clk);
        rst = 1; rf_req = 1;
        #1;
        check("rel_mem_en", mem_en, 1);
        check("rel_mem_adr", mem_adr, RF_A);
        check("rel_rf_stall", rf_stall, 0);
        @(negedge clk);
        rf_req = 0; mem_rdata = 32'hcafe0001;
        #1;
        check("rel_rf_rvalid", rf_rvalid, 1);
        check("rel_rf_rdata", rf_rdata, 32'hcafe0001);
        check("rel_ex_rvalid", ex_rvalid, 0);

        // Vector table: grant cycle then an idle return cycle.
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            rf_req = vecs[i].rf; flush = vecs[i].fl; ex_req = vecs[i].ex;
            ex_we = vecs[i].exwe; dbg_req = vecs[i].dbg; dbg_we = vecs[i].dbgwe;
            #1;
            check($sformatf("v%0d_mem_en", i), mem_en, vecs[i].en);
            check($sformatf("v%0d_mem_we", i), mem_we, vecs[i].we);
            check($sformatf("v%0d_mem_adr", i), mem_adr, exp_adr(vecs[i].src));
            check($sformatf("v%0d_mem_wdata", i), mem_wdata, exp_wdata(vecs[i].src));
            check($sformatf("v%0d_rf_stall", i), rf_stall, vecs[i].rfst);
            check($sformatf("v%0d_ex_stall", i), ex_stall, vecs[i].exst);
            @(negedge clk);
            idle_inputs();
            rd = 32'h5a000000 + 32'(i);
            mem_rdata = rd;
            #1;
            check($sformatf("v%0d_rf_rvalid", i), rf_rvalid, vecs[i].ret == 2'd1);
            check($sformatf("v%0d_ex_rvalid", i), ex_rvalid, vecs[i].ret == 2'd2);
            check($sformatf("v%0d_dbg_ack", i), dbg_ack, vecs[i].ret == 2'd3);
            check($sformatf("v%0d_rdata", i), {rf_rdata, dbg_rdata}, {rd, rd});
            check($sformatf("v%0d_ex_rdata", i), ex_rdata, rd);
        end

        // ex write collides with rf read; rf follows next cycle.
        @(negedge clk);
        ex_req = 1; ex_we = 1; rf_req = 1;
        #1;
        check("col_mem_we", mem_we, 1);
        check("col_mem_adr", mem_adr, EX_A);
        check("col_mem_wdata", mem_wdata, EX_D);
        check("col_rf_stall", rf_stall, 1);
        @(negedge clk);
        ex_req = 0; ex_we = 0;
        #1;
        check("col2_mem_adr", mem_adr, RF_A);
        check("col2_rf_stall", rf_stall, 0);
        check("col2_ex_rvalid", ex_rvalid, 0);

        // Flush in the rf return cycle suppresses the return and the new grant.
        @(negedge clk);
        flush = 1;
        #1;
        check("fl_rf_rvalid", rf_rvalid, 0);
        check("fl_mem_en", mem_en, 0);
        check("fl_rf_stall", rf_stall, 0);
        @(negedge clk);
        idle_inputs();

        // Held debug read: single grant, single ack.
        @(negedge clk);
        dbg_req = 1; dbg_we = 0;
        #1;
        check("dbg_mem_en", mem_en, 1);
        check("dbg_mem_adr", mem_adr, DBG_A);
        @(negedge clk);
        mem_rdata = 32'h0badf00d;
        #1;
        check("dbg_ack_pulse", dbg_ack, 1);
        check("dbg_rdata", dbg_rdata, 32'h0badf00d);
        check("dbg_no_regrant", mem_en, 0);
        @(negedge clk);
        dbg_req = 0;
        #1;
        check("dbg_ack_drop", dbg_ack, 0);

        // Reset in the grant cycle drops the pending debug return.
        @(negedge clk);
        rst = 0; dbg_req = 1;
        @(negedge clk);
        rst = 1; dbg_req = 0;
        #1;
        check("rstmid_dbg_ack", dbg_ack, 0);

        // ex held with debug waiting: guard build forces debug on the 9th cycle.
        @(negedge clk);
        ex_req = 1; ex_we = 1; dbg_req = 1;
        for (int c = 1; c <= 10; c++) begin
            logic exp_dbg;
`ifdef DMEM_ARB_STARVE_GUARD_EN
            exp_dbg = (c == 9);
`else
            exp_dbg = 1'b0;
`endif
            #1;
            check($sformatf("starve_c%0d_adr", c), mem_adr, exp_dbg ? DBG_A : EX_A);
            check($sformatf("starve_c%0d_ex_stall", c), ex_stall, exp_dbg);
            @(negedge clk);
        end
        idle_inputs();
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
